// File: rtl/nq_ram_responder_if.sv
// Request/stall side of the nqcpu memory bus (address, read/write strobes, needWait).
// The bidirectional data lines stay a plain inout on the responder.
interface nq_ram_responder_if;
    logic [15:0] addr_i;
    logic        re_i;
    logic        we_i;
    logic        needWait_o;

    modport master (
        output addr_i,
        output re_i,
        output we_i,
        input  needWait_o
    );

    modport slave (
        input  addr_i,
        input  re_i,
        input  we_i,
        output needWait_o
    );
endinterface

// File: rtl/nq_ram_responder.sv
// Word-wide RAM responder for the nqcpu bus with an address window and programmable wait states.
// Optional access statistics (rd_count_o/wr_count_o) are built when NQRAM_STATS_EN is defined.
module nq_ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h8000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    nq_ram_responder_if.slave bus,
    inout  wire  [15:0]       data_io
`ifdef NQRAM_STATS_EN
    ,
    output logic [15:0]       rd_count_o,
    output logic [15:0]       wr_count_o
`endif
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     mem [DEPTH];

    logic sel;
    logic req;
    logic commit;
    logic rd_drive;
    logic unused_addr0;

    assign sel          = bus.addr_i[15:ADDR_WIDTH+1] == BASE_ADDR[15:ADDR_WIDTH+1];
    assign req          = sel & (bus.re_i ^ bus.we_i);
    assign commit       = (state_q == S_BUSY) && (cnt_q == 4'd0);
    assign unused_addr0 = bus.addr_i[0];

    // Read data is released in the reset cycle itself, not one edge later.
    assign rd_drive = (state_q == S_DONE) && !wr_q && !rst;
    assign data_io  = rd_drive ? data_q : 'z;

    assign bus.needWait_o = (state_q == S_IDLE) ? req : (state_q == S_BUSY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    widx_d  = bus.addr_i[ADDR_WIDTH:1];
                    wr_d    = bus.we_i;
                    wdata_d = data_io;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latched request fields; only meaningful while an access is in flight
    always_ff @(posedge clk) begin
        widx_q  <= widx_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (commit && !wr_q) begin
            data_q <= mem[widx_q];
        end
    end

    // The write lands only on the last BUSY edge, so a reset anywhere earlier aborts it.
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_q) begin
            mem[widx_q] <= wdata_q;
        end
    end

`ifdef NQRAM_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else if (commit) begin
            if (wr_q) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end else begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif

endmodule
